// File: rtl/svc_rv_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Produces op_active (stall request for the hazard unit) combinationally and
// a registered result, presented with result_valid in the DONE cycle.
module svc_rv_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            op_active,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic            is_rem_q;
    logic            neg_q;

    // Operand decode for the start cycle
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            neg_d;

    // Datapath for one restoring step and final sign correction
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] final_mag;
    logic [XLEN-1:0] final_res;

    // Decode op/operands: magnitudes, result sign, and special-case results
    always_comb begin
        is_signed   = ~op[0];
        rs1_neg     = is_signed & rs1[XLEN-1];
        rs2_neg     = is_signed & rs2[XLEN-1];
        rs1_mag     = rs1_neg ? -rs1 : rs1;
        rs2_mag     = rs2_neg ? -rs2 : rs2;
        div_zero    = (rs2 == '0);
        ovf         = is_signed & (rs1 == SMIN) & (rs2 == '1);
        special     = div_zero | ovf;
        // Remainder follows the dividend sign; quotient is negative on sign mismatch
        neg_d       = op[1] ? rs1_neg : (rs1_neg ^ rs2_neg);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? rs1 : '1;
        end else begin
            special_res = op[1] ? '0 : SMIN;
        end
    end

    // One shift-subtract step: quotient bits shift in from the right as the
    // dividend bits shift out of quo_q into the partial remainder
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};
        fits      = ~diff[XLEN];
        step_rem  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], fits};
        final_mag = is_rem_q ? step_rem : step_quo;
        final_res = neg_q ? -final_mag : final_mag;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_rem_q <= op[1];
                        neg_q    <= neg_d;
                        dvs_q    <= rs2_mag;
                        if (special) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= rs1_mag;
                            count_q <= CW'(XLEN - 1);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    if (count_q == '0) begin
                        result_q <= final_res;
                        state_q  <= DONE;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                DONE: begin
                    // start is still the same instruction here; never retrigger
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Busy is combinational so the stall covers the very first EX cycle
    always_comb begin
        op_active    = ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
        result_valid = ~flush & (state_q == DONE);
        result       = result_q;
    end

endmodule

// File: tb/tb_svc_rv_div_iter.sv
// Self-checking bench for svc_rv_div_iter: directed RV32M cases, randomized
// operations against an arithmetic reference, flush, back-to-back and reset.
module tb_svc_rv_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        op_active;
    logic        result_valid;
    logic [31:0] result;

    int errors;
    int checks;

    svc_rv_div_iter #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .rs1          (rs1),
        .rs2          (rs2),
        .op_active    (op_active),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: RISC-V M semantics via native signed/unsigned arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit release_after, input string name);
        logic [31:0] exp;
        logic [31:0] got;
        int          exp_active;
        int          active;
        int          valid_at;
        exp        = ref_div(o, a, b);
        exp_active = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        active   = 0;
        valid_at = -1;
        got      = '0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
            #1;
            if (op_active) active++;
            if (result_valid) begin
                valid_at = i;
                got      = result;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (valid_at !== exp_active) begin
            errors++;
            $display("FAIL %s valid_cycle: got %0d expected %0d", name, valid_at, exp_active);
        end
        checks++;
        if (active !== exp_active) begin
            errors++;
            $display("FAIL %s active_cycles: got %0d expected %0d", name, active, exp_active);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s result: op=%0d a=%h b=%h got %h expected %h", name, o, a, b, got, exp);
        end
        if (release_after) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (op_active !== 1'b0 || result_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after: active=%b valid=%b expected 0 0", name, op_active, result_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        rs1 = '0;
        rs2 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (op_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", op_active); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op(2'b01, 32'd100, 32'd7, 1'b1, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, 1'b1, "remu_100_7");
        do_op(2'b00, -32'sd7, 32'd2, 1'b1, "div_m7_2");
        do_op(2'b10, -32'sd7, 32'd2, 1'b1, "rem_m7_2");
        do_op(2'b10, 32'd7, -32'sd2, 1'b1, "rem_7_m2");
        do_op(2'b01, 32'h1234, 32'd0, 1'b1, "divu_by0");
        do_op(2'b11, 32'h1234, 32'd0, 1'b1, "remu_by0");
        do_op(2'b00, 32'hFFFF_FFF0, 32'd0, 1'b1, "div_by0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "rem_ovf");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divu_big");
        do_op(2'b00, 32'h8000_0000, 32'd1, 1'b1, "div_min_1");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(o, a, b, 1'b1, "random");
        end
    endtask

    task automatic test_flush();
        // Abort in BUSY
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (op_active !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_same: active=%b valid=%b expected 0 0", op_active, result_valid);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (op_active !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_next: active=%b valid=%b expected 0 0", op_active, result_valid);
        end
        do_op(2'b01, 32'd9, 32'd3, 1'b1, "after_flush");
        // Flush in DONE suppresses result_valid
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd5; rs2 = 32'd0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: valid=%b expected 0", result_valid);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (op_active !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_next: active=%b valid=%b expected 0 0", op_active, result_valid);
        end
        // Flush together with start in IDLE must not launch
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd5; rs2 = 32'd0;
        #1;
        checks++;
        if (op_active !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: active=%b expected 0", op_active);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (result_valid !== 1'b0 || op_active !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_next: active=%b valid=%b expected 0 0", op_active, result_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, 32'd1000, -32'sd3, 1'b0, "b2b_first");
        do_op(2'b11, 32'hDEAD_BEEF, 32'd1000, 1'b0, "b2b_second");
        do_op(2'b01, 32'd77, 32'd0, 1'b0, "b2b_special");
        do_op(2'b10, -32'sd1000, 32'd7, 1'b1, "b2b_last");
    endtask

    task automatic test_reset_mid();
        do_op(2'b01, 32'd100, 32'd7, 1'b1, "pre_reset");
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd500; rs2 = 32'd3;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if (op_active !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl: active=%b valid=%b expected 0 0", op_active, result_valid);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_result: got %h expected 0", result);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(2'b11, 32'd500, 32'd3, 1'b1, "post_reset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
